// File: rtl/popcount_arbiter.sv
`default_nettype none
// ============================================================================
// popcount_arbiter: round-robin share of one popcount counter, in-order tag return. Rev 1.0
// ============================================================================
module popcount_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(WIDTH) + 1,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [N_REQ*WIDTH-1:0] req_data_i,
  input  logic [N_REQ-1:0]       req_val_i,
  output logic [N_REQ-1:0]       req_rdy_o,
  output logic [WIDTH-1:0]       pc_data_o,
  output logic                   pc_data_val_o,
  input  logic [CNT_W-1:0]       pc_data_i,
  input  logic                   pc_data_val_i,
  output logic [CNT_W-1:0]       resp_data_o,
  output logic [ID_W-1:0]        resp_id_o,
  output logic                   resp_val_o,
  output logic                   err_o
);

  localparam int                PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                FCNT_W    = $clog2(DEPTH + 1);
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(N_REQ - 1);
  localparam logic [ID_W:0]     N_EXT     = (ID_W + 1)'(N_REQ);
  localparam logic [PTR_W-1:0]  LAST_SLOT = PTR_W'(DEPTH - 1);
  localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(DEPTH);

  logic [WIDTH-1:0]  words [N_REQ];
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   grant_id;
  logic              grant_vld;
  logic [ID_W:0]     cand;
  logic [ID_W-1:0]   fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FCNT_W-1:0] fifo_cnt;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign words[g] = req_data_i[g*WIDTH +: WIDTH];
  end

  // Search starts at ptr and wraps; a full FIFO (pre-pop count) blocks every grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr} + (ID_W + 1)'(i);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!grant_vld && (fifo_cnt < FULL_CNT) && req_val_i[cand[ID_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_rdy_o = '0;
    if (grant_vld) req_rdy_o[grant_id] = 1'b1;
  end

  assign fifo_empty = (fifo_cnt == '0);
  assign push       = grant_vld;
  assign pop        = pc_data_val_i & ~fifo_empty;

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= grant_id;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_cnt      <= '0;
      pc_data_o     <= '0;
      pc_data_val_o <= 1'b0;
      resp_data_o   <= '0;
      resp_id_o     <= '0;
      resp_val_o    <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      pc_data_val_o <= push;
      resp_val_o    <= pop;
      if (push) begin
        pc_data_o <= words[grant_id];
        ptr       <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        wr_ptr    <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        resp_data_o <= pc_data_i;
        resp_id_o   <= fifo_mem[rd_ptr];
        rd_ptr      <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + 1'b1;
      end
      // A result with no outstanding tag means the counter and tag stream lost sync.
      if (pc_data_val_i && fifo_empty) err_o <= 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_popcount_arbiter.sv
`default_nettype none
// tb_popcount_arbiter: randomized and directed checks against a queue-based reference model.
module tb_popcount_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int CW = $clog2(W) + 1;
  localparam int IW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] req_data;
  logic [W-1:0]   word [N];
  logic [N-1:0]   req_val;
  logic [N-1:0]   req_rdy;
  logic [W-1:0]   pc_data;
  logic           pc_data_val;
  logic [CW-1:0]  pc_res;
  logic           pc_res_val;
  logic [CW-1:0]  resp_data;
  logic [IW-1:0]  resp_id;
  logic           resp_val;
  logic           err;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_data[g*W +: W] = word[g];
  end

  always #5 clk = ~clk;

  popcount_arbiter #(.N_REQ(N), .WIDTH(W), .DEPTH(D)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_data_i(req_data), .req_val_i(req_val), .req_rdy_o(req_rdy),
    .pc_data_o(pc_data), .pc_data_val_o(pc_data_val),
    .pc_data_i(pc_res), .pc_data_val_i(pc_res_val),
    .resp_data_o(resp_data), .resp_id_o(resp_id), .resp_val_o(resp_val),
    .err_o(err)
  );

  typedef struct { int id; int cnt; } tag_t;
  tag_t tagq[$];
  int   ctr_q[$];
  int   ref_ptr, last_gid, mode;
  bit   one_shot, spurious;
  logic [W-1:0]  exp_pc_data;
  logic          exp_pc_val, exp_resp_val, exp_err;
  logic [CW-1:0] exp_resp_data;
  logic [IW-1:0] exp_resp_id;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    tagq.delete(); ctr_q.delete();
    ref_ptr = 0; last_gid = -1; one_shot = 0; spurious = 0;
    exp_pc_data = '0; exp_pc_val = 0; exp_resp_val = 0; exp_err = 0;
    exp_resp_data = '0; exp_resp_id = '0;
  endtask

  task automatic check_outputs();
    chk("pc_data_val", pc_data_val, exp_pc_val);
    chk("pc_data", pc_data, exp_pc_data);
    chk("resp_val", resp_val, exp_resp_val);
    chk("resp_data", resp_data, exp_resp_data);
    chk("resp_id", resp_id, exp_resp_id);
    chk("err", err, exp_err);
  endtask

  // One clock: counter model drives its result, grant is predicted, edge, outputs checked.
  task automatic cycle();
    int sz, gid;
    logic [N-1:0] erdy;
    tag_t t;
    pc_res_val = 1'b0;
    if (spurious) begin
      pc_res_val = 1'b1; pc_res = CW'($urandom); spurious = 0;
    end else if (ctr_q.size() > 0 &&
                 (mode == 2 || one_shot || (mode == 0 && $urandom_range(0, 2) != 0))) begin
      pc_res_val = 1'b1; pc_res = CW'(ctr_q.pop_front()); one_shot = 0;
    end
    #1;
    sz = tagq.size();
    gid = -1;
    if (sz < D)
      for (int i = 0; i < N; i++)
        if (gid < 0 && req_val[(ref_ptr + i) % N]) gid = (ref_ptr + i) % N;
    erdy = (gid < 0) ? '0 : N'(1 << gid);
    chk("req_rdy", req_rdy, erdy);
    exp_resp_val = 0;
    if (pc_res_val) begin
      if (sz > 0) begin
        t = tagq.pop_front();
        exp_resp_val = 1; exp_resp_id = IW'(t.id); exp_resp_data = CW'(t.cnt);
      end else exp_err = 1;
    end
    exp_pc_val = 0;
    if (gid >= 0) begin
      tagq.push_back('{id: gid, cnt: $countones(word[gid])});
      exp_pc_val = 1; exp_pc_data = word[gid];
      ref_ptr = (gid + 1) % N;
    end
    last_gid = gid;
    @(posedge clk); #1;
    check_outputs();
    if (pc_data_val) ctr_q.push_back($countones(pc_data));
  endtask

  task automatic drain();
    req_val = '0; mode = 2;
    for (int b = 0; b < 60; b++) begin
      if (tagq.size() == 0 && ctr_q.size() == 0) break;
      cycle();
    end
    chk("drain_tags_left", tagq.size(), 0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return '0;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; req_val = '0; pc_res = '0; pc_res_val = 1'b0; mode = 0;
    for (int k = 0; k < N; k++) word[k] = '0;
    model_reset();
    #3;
    check_outputs();
    chk("rst_rdy_idle", req_rdy, 4'b0000);
    req_val = 4'b1000; #1;
    chk("rst_rdy_req3", req_rdy, 4'b1000);
    req_val = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single requester held on req 2
    word[2] = 16'h00FF; req_val = 4'b0100; mode = 2;
    repeat (12) cycle();
    // All four requesting every cycle
    word[0] = 16'h0001; word[1] = 16'h0003; word[2] = 16'h0007; word[3] = 16'h000F;
    req_val = 4'b1111;
    repeat (16) cycle();
    mode = 0;
    repeat (16) cycle();
    // FIFO full with the counter stalled, then a single release
    mode = 1;
    repeat (8) cycle();
    one_shot = 1;
    repeat (4) cycle();
    drain();
    // Edge values
    word[0] = 16'hFFFF; word[1] = 16'h0000; req_val = 4'b0011; mode = 2;
    repeat (6) cycle();
    drain();
    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < N; k++)
        if (!req_val[k] || last_gid == k) word[k] = pick();
      req_val = N'($urandom);
      if (n % 25 == 0) mode = $urandom_range(0, 2);
      cycle();
    end
    drain();
    // Spurious result with an empty FIFO
    req_val = '0; spurious = 1;
    cycle();
    repeat (3) cycle();
    req_val = 4'b1111; mode = 2;
    repeat (5) cycle();
    drain();
    // Reset with three tags in flight
    mode = 1; word[1] = 16'h1234; req_val = 4'b0010;
    repeat (3) cycle();
    req_val = '0; pc_res_val = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("midrst_rdy", req_rdy, 4'b0000);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    req_val = 4'b1111; mode = 2;
    cycle();
    chk("first_grant_after_rst", last_gid, 0);
    repeat (4) cycle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
